// File: rtl/serial_parity_checker.sv
// Receiver for start/data/parity/stop bit-serial frames: rebuilds the data word
// and reports parity and framing errors with a one-cycle valid pulse.
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              rxor_q, rxor_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_out_q, perr_out_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    rxor_d     = rxor_q;
    perr_d     = perr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;
    // Every piece of frame state only moves on a qualified strobe.
    if (rx_en) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_bit) begin
            state_d = S_DATA;
            cnt_d   = '0;
            shreg_d = '0;
            rxor_d  = 1'b0;
          end
        end
        S_DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CW'(i)) shreg_d[i] = rx_bit;
          end
          rxor_d = rxor_q ^ rx_bit;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_PARITY;
        end
        S_PARITY: begin
          perr_d  = rxor_q ^ rx_bit ^ ODD_PARITY;
          state_d = S_STOP;
        end
        S_STOP: begin
          // Frames with a bad stop bit are still delivered, flagged.
          data_d     = shreg_q;
          perr_out_d = perr_q;
          ferr_d     = ~rx_bit;
          valid_d    = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      rxor_q     <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      rxor_q     <= rxor_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive side of the parity-protected half-adder result path. The block deserializes a bit-serial frame (start bit, DATA_W data bits LSB-first, one parity bit, stop bit) and recomputes parity over the received data bits. It presents the recovered word with one-cycle valid, parity-error and framing-error flags. It sits downstream of the sum/parity generator and lets the bench or the consuming logic confirm that ep/op-style parity survived transport.

## Interface
- DATA_W, default 8: number of data bits per frame; legal range 1..32.
- ODD_PARITY, default 0: 0 selects even parity (ones in data plus parity bit is even), 1 selects odd parity.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- rx_en  input  1  bit strobe; rx_bit is sampled only on clock edges where rx_en=1.
- rx_bit  input  1  serial line; idle level 1.
- data_out  output  DATA_W  last received word, LSB = first data bit on the line.
- valid  output  1  one-cycle pulse: frame complete; data_out and flags are updated.
- parity_err  output  1  received parity bit mismatches the recomputed parity of the last frame.
- frame_err  output  1  stop bit of the last frame sampled as 0.
- busy  output  1  high from the start-bit sample until the stop-bit sample.

## Operation
- The FSM has four states: IDLE, DATA, PARITY, STOP. Transitions happen only on edges with rx_en=1. With rx_en=0, state, counter, shift register and running parity all hold.
- IDLE: rx_bit=1 stays in IDLE. rx_bit=0 is taken as the start bit: go to DATA, clear bit counter, shift register and running XOR.
- DATA: shift rx_bit into shreg[cnt] (LSB-first), XOR rx_bit into the running parity, increment cnt. At the sample with cnt=DATA_W-1, go to PARITY.
- PARITY: capture the parity bit. perr = running_xor ^ rx_bit ^ ODD_PARITY. Go to STOP.
- STOP: sample the stop bit. On that edge, load data_out with shreg and load parity_err with perr. Load frame_err with ~rx_bit and pulse valid. Return to IDLE.
- A frame with frame_err=1 is still delivered: valid pulses and data_out updates. There is no resynchronisation search.
- data_out, parity_err and frame_err change only on the valid edge. They hold until the next valid or reset.
- There is no back-to-back idle requirement. A start bit sampled on the first rx_en edge after STOP is accepted.
- Counter width is clog2(DATA_W)+1 bits. Internal parity is a 1-bit XOR accumulator; there is no width growth.

## Timing
- Reset values: data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE.
- Latency: valid is registered on the same clock edge that samples the stop bit. It is high for exactly one cycle after that edge, regardless of rx_en in the next cycle.
- busy rises on the start-bit sampling edge. It falls on the stop-bit sampling edge, the same edge valid rises.
- A frame occupies exactly DATA_W+3 rx_en-qualified samples. Gaps of any length between strobes are legal.
- Reset asserted mid-frame: the partial frame is discarded and there is no valid pulse. After reset deasserts, the block waits for a new start bit in IDLE.
- Reset asserted in the same cycle as a stop-bit sample: reset wins, so no valid pulse and the outputs stay at their reset values.
- rx_en held at 1 every cycle is the fastest rate: one frame per DATA_W+3 cycles.

## Test plan
- Even parity, DATA_W=8, rx_en=1 continuously. Send 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB-first, parity 0, stop 1). Required: valid one cycle after the 11th edge, data_out=0xA5, parity_err=0, frame_err=0.
- Same frame with the parity bit flipped to 1. Required: data_out=0xA5, parity_err=1, frame_err=0.
- ODD_PARITY=1: send 0x01 with parity bit 0 and stop bit 1. Required: parity_err=0. Resend with parity bit 1: parity_err=1.
- Stop bit 0 on 0x3C with correct even parity 0. Required: valid pulses, data_out=0x3C, frame_err=1, parity_err=0. A following clean 0xFF frame clears both flags.
- rx_en toggled 1-0-0-1 across a 0x5A frame. Required: identical result to the continuous case (data_out=0x5A, no errors). busy stays high through the gaps.
- Reset pulsed after 4 data bits of 0xFF. Required: no valid pulse, busy=0 and all outputs 0 immediately. A next full 0x81 frame decodes correctly with parity_err=0.
